bomb_array_ctrl: RTL
====================

BOMB_ARRAY_CTRL -- requirements
Module: bomb_array_ctrl

Interface
REQ-001 Parameter NUM_BOMBS, default 4, meaning number of independent bomb slots (1..16).
REQ-002 Parameter CNT_W, default 8, meaning width of every fuse/explosion counter.
REQ-003 Parameter FUSE_FRAMES, default 79, meaning fuse length in frames; must exceed BLINK_FRAMES and fit CNT_W.
REQ-004 Parameter BLINK_FRAMES, default 5, meaning initial frames of fuse with bomb sprite hidden.
REQ-005 Parameter EXPLODE_FRAMES, default 10, meaning explosion length in frames; fits CNT_W.
REQ-006 Clk  input  1  sole clock; all state updates on rising edge.
REQ-007 Reset  input  1  asynchronous, active-low reset.
REQ-008 VGA_VS  input  1  vertical sync, asynchronous to Clk, frame time base.
REQ-009 place_req  input  1  request to arm one new bomb.
REQ-010 detonate  input  NUM_BOMBS  per-slot forced detonation (chain reaction).
REQ-011 place_ack  output  1  one-cycle pulse, placement accepted.
REQ-012 place_slot  output  max(1,$clog2(NUM_BOMBS))  slot index of accepted placement, valid with place_ack.
REQ-013 full  output  1  no slot in IDLE.
REQ-014 active_count  output  $clog2(NUM_BOMBS+1)  number of slots not in IDLE.
REQ-015 bomb_placed, bomb_exploding, bomb_exploded, bomb_on  output  NUM_BOMBS each  per-slot status.

Function
REQ-016 VGA_VS shall pass a 2-flop synchronizer plus one history flop; frame_tick = rising edge of synchronized VS, one Clk cycle wide, 3 cycles after VS edge.
REQ-017 Each slot shall run its own FSM: IDLE, FUSE, EXPLODE, DONE.
REQ-018 Placement: in a cycle with place_req=1 and full=0, the lowest-index IDLE slot enters FUSE with fuse_cnt=FUSE_FRAMES; place_ack=1 and place_slot=index registered, visible next cycle.
REQ-019 At most one placement per cycle; place_req held high arms one slot per cycle until full.
REQ-020 place_req while full=1: no ack, no state change, request not queued.
REQ-021 FUSE: fuse_cnt decrements by 1 per frame_tick, saturating at 0; when fuse_cnt==0 the slot enters EXPLODE next cycle with expl_cnt=EXPLODE_FRAMES.
REQ-022 EXPLODE: expl_cnt decrements per frame_tick, saturating at 0; when 0, enters DONE.
REQ-023 DONE lasts exactly one Clk cycle, then IDLE.
REQ-024 detonate[i]=1 with slot i in FUSE: next cycle EXPLODE, expl_cnt=EXPLODE_FRAMES; detonate and frame_tick same cycle -> detonate wins, no decrement.
REQ-025 detonate[i] in IDLE, EXPLODE or DONE shall be ignored.
REQ-026 Outputs per slot: bomb_placed=1 in FUSE; bomb_exploding=1 in EXPLODE; bomb_exploded=1 in DONE; bomb_on=1 in FUSE when fuse_cnt < FUSE_FRAMES-BLINK_FRAMES, and in EXPLODE and DONE; else 0.
REQ-027 full and active_count shall be combinational from current slot states; a slot in DONE is not free.
REQ-028 Status outputs shall be combinational from registered state only (no input-to-output paths).

Reset
REQ-029 While Reset=0: all slots IDLE, all counters 0, place_ack=0, place_slot=0, all status outputs 0, full=0, active_count=0.
REQ-030 Synchronizer and history flops shall reset to 1, so no frame_tick is generated by VS level at reset release.
REQ-031 Reset asserted mid-fuse or mid-explosion shall abort immediately to REQ-029 values; no ack or DONE pulse after release.

Verification (NUM_BOMBS=2, FUSE_FRAMES=4, BLINK_FRAMES=1, EXPLODE_FRAMES=2)
REQ-032 Single place, VS toggling -> ack slot 0; bomb_on[0] 0 for first frame, 1 after 2nd tick; EXPLODE after 4 ticks for 2 ticks; bomb_exploded[0] one-cycle pulse; back to IDLE.
REQ-033 place_req held 3 cycles from empty -> acks slot 0 then slot 1; third cycle no ack, full=1, active_count=2.
REQ-034 Slot 0 in FUSE, detonate=2'b01 coincident with frame_tick -> next cycle bomb_exploding[0]=1, expl_cnt=2; slot 1 unaffected.
REQ-035 Both full, slot 0 in DONE plus place_req same cycle -> no ack; next cycle slot 0 IDLE, place_req -> ack slot 0.
REQ-036 VS held high through reset release -> no frame_tick until next VS rising edge; Reset pulsed low mid-explosion -> all outputs 0, stay IDLE.

Source files
------------

// File: rtl/bomb_array_ctrl.sv
// Bomb slot array: frame-synchronised fuse/explosion timers with lowest-free-slot
// allocation, forced detonation and per-slot sprite status.
module bomb_array_ctrl #(
  parameter int NUM_BOMBS      = 4,
  parameter int CNT_W          = 8,
  parameter int FUSE_FRAMES    = 79,
  parameter int BLINK_FRAMES   = 5,
  parameter int EXPLODE_FRAMES = 10,
  localparam int SLOT_W        = (NUM_BOMBS > 1) ? $clog2(NUM_BOMBS) : 1,
  localparam int ACT_W         = $clog2(NUM_BOMBS + 1)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 VGA_VS,
  input  logic                 place_req,
  input  logic [NUM_BOMBS-1:0] detonate,
  output logic                 place_ack,
  output logic [SLOT_W-1:0]    place_slot,
  output logic                 full,
  output logic [ACT_W-1:0]     active_count,
  output logic [NUM_BOMBS-1:0] bomb_placed,
  output logic [NUM_BOMBS-1:0] bomb_exploding,
  output logic [NUM_BOMBS-1:0] bomb_exploded,
  output logic [NUM_BOMBS-1:0] bomb_on
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FUSE,
    S_EXPLODE,
    S_DONE
  } slot_state_t;

  localparam logic [CNT_W-1:0] FUSE_CNT    = CNT_W'(FUSE_FRAMES);
  localparam logic [CNT_W-1:0] EXPLODE_CNT = CNT_W'(EXPLODE_FRAMES);
  localparam logic [CNT_W-1:0] VISIBLE_LT  = CNT_W'(FUSE_FRAMES - BLINK_FRAMES);

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  slot_state_t            state [NUM_BOMBS];
  logic [CNT_W-1:0]       cnt   [NUM_BOMBS];

  logic                   vs_p0, vs_p1, vs_p2;
  logic                   frame_tick;
  logic                   free_found;
  logic [SLOT_W-1:0]      free_idx;
  logic                   place_go;

  // Stage p0/p1: two-flop VS synchroniser; p2: history flop for edge detect.
  // Preset to 1 so a VS already high at reset release is not seen as an edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vs_p0 <= 1'b1;
      vs_p1 <= 1'b1;
      vs_p2 <= 1'b1;
    end else begin
      vs_p0 <= VGA_VS;
      vs_p1 <= vs_p0;
      vs_p2 <= vs_p1;
    end
  end

  assign frame_tick = vs_p1 & ~vs_p2;

  // Lowest-index IDLE slot wins; scanning downward lets the low index overwrite.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
      if (state[i] == S_IDLE) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

  assign full     = ~free_found;
  assign place_go = place_req & free_found;

  // Slot FSMs and placement handshake, all registered.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      place_ack  <= 1'b0;
      place_slot <= '0;
      for (int i = 0; i < NUM_BOMBS; i++) begin
        state[i] <= S_IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      place_ack <= place_go;
      if (place_go) begin
        place_slot <= free_idx;
      end
      for (int i = 0; i < NUM_BOMBS; i++) begin
        case (state[i])
          S_IDLE: begin
            if (place_go && (free_idx == SLOT_W'(i))) begin
              state[i] <= S_FUSE;
              cnt[i]   <= FUSE_CNT;
            end
          end
          S_FUSE: begin
            // Forced detonation takes priority over a coincident frame tick.
            if (detonate[i] || (cnt[i] == '0)) begin
              state[i] <= S_EXPLODE;
              cnt[i]   <= EXPLODE_CNT;
            end else if (frame_tick) begin
              cnt[i] <= sat_dec(cnt[i]);
            end
          end
          S_EXPLODE: begin
            if (cnt[i] == '0) begin
              state[i] <= S_DONE;
            end else if (frame_tick) begin
              cnt[i] <= sat_dec(cnt[i]);
            end
          end
          S_DONE: begin
            state[i] <= S_IDLE;
          end
          default: begin
            state[i] <= S_IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Status decode from registered slot state only.
  always_comb begin
    active_count   = '0;
    bomb_placed    = '0;
    bomb_exploding = '0;
    bomb_exploded  = '0;
    bomb_on        = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (state[i] != S_IDLE) begin
        active_count = active_count + ACT_W'(1);
      end
      bomb_placed[i]    = (state[i] == S_FUSE);
      bomb_exploding[i] = (state[i] == S_EXPLODE);
      bomb_exploded[i]  = (state[i] == S_DONE);
      bomb_on[i]        = ((state[i] == S_FUSE) && (cnt[i] < VISIBLE_LT)) ||
                          (state[i] == S_EXPLODE) || (state[i] == S_DONE);
    end
  end

endmodule
